// File: rtl/arb_mux_reg_pkg.sv
// Shared constants for the arbitrated output mux: arbitration mode encodings
// and the default payload width used by the datapath.
package arb_mux_reg_pkg;
   localparam int ARB_FIXED     = 0;
   localparam int ARB_RR        = 1;
   localparam int WORD_SIZE_DEF = 32;
endpackage

// File: rtl/arb_mux_reg_rr_pick.sv
// Combinational picker: first requesting channel starting from ptr_i (round-robin)
// or from channel 0 (fixed priority). Returns a one-hot grant plus its index.
module rr_pick
   import arb_mux_reg_pkg::*;
#(
   parameter  int NUM_CH   = 4,
   parameter  int ARB_MODE = ARB_RR,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   int          start_v;
   int          c_v;
   logic [CH_W-1:0] cand_v;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      c_v     = 0;
      cand_v  = '0;
      start_v = (ARB_MODE == ARB_RR) ? int'(ptr_i) : 0;
      // Explicit wrap rather than %, so non-power-of-2 channel counts work.
      for (int k = 0; k < NUM_CH; k++) begin
         c_v = start_v + k;
         if (c_v >= NUM_CH) c_v = c_v - NUM_CH;
         cand_v = CH_W'(c_v);
         if (!any_o && req_i[cand_v]) begin
            any_o           = 1'b1;
            grant_o[cand_v] = 1'b1;
            idx_o           = cand_v;
         end
      end
   end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N:1 channel mux with internal arbitration and valid/ready on both sides.
// One output register gives 1-cycle latency at full throughput.
module arb_mux_reg
   import arb_mux_reg_pkg::*;
#(
   parameter  int WORD_SIZE = WORD_SIZE_DEF,
   parameter  int NUM_CH    = 4,
   parameter  int ARB_MODE  = ARB_RR,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
   output logic [NUM_CH-1:0]           in_ready,
   output logic                        out_valid,
   output logic [WORD_SIZE-1:0]        out_data,
   output logic [CH_W-1:0]             out_ch,
   input  logic                        out_ready
);

   logic                 out_valid_q, out_valid_d;
   logic [WORD_SIZE-1:0] out_data_q,  out_data_d;
   logic [CH_W-1:0]      out_ch_q,    out_ch_d;
   logic [CH_W-1:0]      rr_ptr_q,    rr_ptr_d;

   logic [NUM_CH-1:0]    grant;
   logic [CH_W-1:0]      g_idx;
   logic                 any_req;
   logic                 load;

   rr_pick #(
      .NUM_CH   (NUM_CH),
      .ARB_MODE (ARB_MODE)
   ) u_pick (
      .req_i   (in_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (g_idx),
      .any_o   (any_req)
   );

   // Refill allowed when the register is empty or being drained this cycle.
   assign load     = any_req && (!out_valid_q || out_ready);
   assign in_ready = load ? grant : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(g_idx)*WORD_SIZE +: WORD_SIZE];
         out_ch_d    = g_idx;
         if (ARB_MODE == ARB_RR) begin
            rr_ptr_d = (int'(g_idx) == NUM_CH-1) ? '0 : g_idx + 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: 4-ch round-robin, 3-ch round-robin wrap,
// and 4-ch fixed-priority instances sharing one clock and reset.
module tb_arb_mux_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]   in_valid4, in_ready4;
   logic [127:0] in_data4;
   logic         out_valid4, out_ready4;
   logic [31:0]  out_data4;
   logic [1:0]   out_ch4;

   logic [2:0]   in_valid3, in_ready3;
   logic [47:0]  in_data3;
   logic         out_valid3, out_ready3;
   logic [15:0]  out_data3;
   logic [1:0]   out_ch3;

   logic [3:0]   in_valid_f, in_ready_f;
   logic [63:0]  in_data_f;
   logic         out_valid_f, out_ready_f;
   logic [15:0]  out_data_f;
   logic [1:0]   out_ch_f;

   int n_tests = 0;
   int n_fail  = 0;

   arb_mux_reg #(.WORD_SIZE(32), .NUM_CH(4), .ARB_MODE(1)) u_rr4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
      .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4), .out_ready(out_ready4));

   arb_mux_reg #(.WORD_SIZE(16), .NUM_CH(3), .ARB_MODE(1)) u_rr3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3));

   arb_mux_reg #(.WORD_SIZE(16), .NUM_CH(4), .ARB_MODE(0)) u_fx (
      .clk(clk), .rst(rst), .in_valid(in_valid_f), .in_data(in_data_f), .in_ready(in_ready_f),
      .out_valid(out_valid_f), .out_data(out_data_f), .out_ch(out_ch_f), .out_ready(out_ready_f));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      in_valid4 = '0; in_valid3 = '0; in_valid_f = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid4); end
      n_tests++; if (out_data4 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data4); end
      n_tests++; if (out_ch4 !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", out_ch4); end
      rst = 1'b0;
      in_valid4 = 4'b1111; out_ready4 = 1'b1;
      tick();
      tick();
      n_tests++; if (out_ch4 !== 2'd1) begin n_fail++; $display("FAIL pre_reset_ch: got %0d want 1", out_ch4); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid4); end
      n_tests++; if (out_data4 !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", out_data4); end
      n_tests++; if (out_ch4 !== 2'd0) begin n_fail++; $display("FAIL midrst_ch: got %0d want 0", out_ch4); end
      #2 rst = 1'b0;
      tick();
      n_tests++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0 || out_data4 !== 32'hA000_0000) begin
         n_fail++; $display("FAIL post_reset_grant: got v=%b ch=%0d d=%h want v=1 ch=0 d=a0000000", out_valid4, out_ch4, out_data4);
      end
      in_valid4 = '0;
      tick();
   endtask

   task automatic test_single();
      pulse_reset();
      in_data4[64 +: 32] = 32'hDEADBEEF;
      in_valid4 = 4'b0100; out_ready4 = 1'b1;
      #1;
      n_tests++; if (in_ready4 !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", in_ready4); end
      tick();
      n_tests++; if (out_valid4 !== 1'b1 || out_data4 !== 32'hDEADBEEF || out_ch4 !== 2'd2) begin
         n_fail++; $display("FAIL single_out: got v=%b d=%h ch=%0d want v=1 d=deadbeef ch=2", out_valid4, out_data4, out_ch4);
      end
      in_valid4 = '0;
      #1;
      n_tests++; if (in_ready4 !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b want 0000", in_ready4); end
      tick();
      n_tests++; if (out_valid4 !== 1'b0 || out_data4 !== 32'hDEADBEEF || out_ch4 !== 2'd2) begin
         n_fail++; $display("FAIL drain_hold: got v=%b d=%h ch=%0d want v=0 d=deadbeef ch=2", out_valid4, out_data4, out_ch4);
      end
      in_data4[64 +: 32] = 32'hA000_0002;
   endtask

   task automatic test_rr_fairness();
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      pulse_reset();
      in_valid4 = 4'b1111; out_ready4 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++;
         if (out_valid4 !== 1'b1 || out_ch4 !== 2'(exp_seq[i]) || out_data4 !== 32'hA000_0000 + 32'(exp_seq[i])) begin
            n_fail++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d", i, out_valid4, out_ch4, out_data4, exp_seq[i]);
         end
      end
      in_valid4 = '0;
      tick(); tick(); tick();
      n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rr_idle_valid: got %b want 0", out_valid4); end
      in_valid4 = 4'b1111;
      #1;
      n_tests++; if (in_ready4 !== 4'b0100) begin n_fail++; $display("FAIL rr_idle_hold_ready: got %b want 0100", in_ready4); end
      tick();
      n_tests++; if (out_ch4 !== 2'd2) begin n_fail++; $display("FAIL rr_idle_hold_ch: got %0d want 2", out_ch4); end
      in_valid4 = '0;
      tick();
   endtask

   task automatic test_backpressure();
      pulse_reset();
      in_valid4 = 4'b0001; out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0; in_valid4 = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (in_ready4 !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready4); end
         tick();
         n_tests++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd0 || out_data4 !== 32'hA000_0000) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=0 d=a0000000", i, out_valid4, out_ch4, out_data4);
         end
      end
      out_ready4 = 1'b1;
      #1;
      n_tests++; if (in_ready4 !== 4'b0010) begin n_fail++; $display("FAIL unstall_ready: got %b want 0010", in_ready4); end
      tick();
      n_tests++; if (out_valid4 !== 1'b1 || out_ch4 !== 2'd1 || out_data4 !== 32'hA000_0001) begin
         n_fail++; $display("FAIL unstall_out: got v=%b ch=%0d d=%h want v=1 ch=1 d=a0000001", out_valid4, out_ch4, out_data4);
      end
      in_valid4 = '0;
      tick();
   endtask

   task automatic test_wrap();
      pulse_reset();
      in_valid3 = 3'b100; out_ready3 = 1'b1;
      tick();
      n_tests++; if (out_ch3 !== 2'd2 || out_data3 !== 16'hB002) begin
         n_fail++; $display("FAIL wrap_ch2: got ch=%0d d=%h want ch=2 d=b002", out_ch3, out_data3);
      end
      in_valid3 = 3'b011;
      #1;
      n_tests++; if (in_ready3 !== 3'b001) begin n_fail++; $display("FAIL wrap_ready: got %b want 001", in_ready3); end
      tick();
      n_tests++; if (out_ch3 !== 2'd0) begin n_fail++; $display("FAIL wrap_ch0: got %0d want 0", out_ch3); end
      tick();
      n_tests++; if (out_ch3 !== 2'd1 || out_data3 !== 16'hB001) begin
         n_fail++; $display("FAIL wrap_ch1: got ch=%0d d=%h want ch=1 d=b001", out_ch3, out_data3);
      end
      in_valid3 = '0;
      tick();
   endtask

   task automatic test_fixed();
      pulse_reset();
      in_valid_f = 4'b1010; out_ready_f = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++; if (in_ready_f !== 4'b0010) begin n_fail++; $display("FAIL fixed_ready[%0d]: got %b want 0010", i, in_ready_f); end
         tick();
         n_tests++; if (out_ch_f !== 2'd1 || out_data_f !== 16'hC001) begin
            n_fail++; $display("FAIL fixed_ch[%0d]: got ch=%0d d=%h want ch=1 d=c001", i, out_ch_f, out_data_f);
         end
      end
      in_valid_f = 4'b1000;
      tick();
      n_tests++; if (out_ch_f !== 2'd3 || out_data_f !== 16'hC003) begin
         n_fail++; $display("FAIL fixed_ch3: got ch=%0d d=%h want ch=3 d=c003", out_ch_f, out_data_f);
      end
      in_valid_f = '0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      in_valid4 = '0; in_valid3 = '0; in_valid_f = '0;
      out_ready4 = 1'b0; out_ready3 = 1'b0; out_ready_f = 1'b0;
      in_data4  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      in_data3  = {16'hB002, 16'hB001, 16'hB000};
      in_data_f = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
      test_reset();
      test_single();
      test_rr_fairness();
      test_backpressure();
      test_wrap();
      test_fixed();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
